// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and constants for the firebird7_in_gate1 IJTAG override mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

  typedef enum logic {
    CH_ACTIVE = 1'b0,
    CH_HOLD   = 1'b1
  } ch_state_t;

  localparam int CNT_W = 4;

  // Bits per channel in the IJTAG data register: {sel, data}.
  function automatic int slice_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_chan.sv
// One override channel: select FSM, settle counter, hold register and output mux.
module firebird7_in_gate1_tessent_data_mux_chan
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_upd_en,
  input  logic             i_new_sel,
  input  logic             i_upd_sel,
  input  logic [WIDTH-1:0] i_upd_data,
  input  logic [WIDTH-1:0] i_func_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy,
  output logic             o_eff_sel
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  ch_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_eff_sel, w_eff_sel_nxt;
  logic             w_sel_change;
  logic [WIDTH-1:0] w_data;

  assign w_sel_change = i_upd_en && (i_new_sel != i_upd_sel);

  assign w_data    = (r_state == CH_HOLD) ? r_hold
                   : (r_eff_sel ? i_upd_data : i_func_data);
  assign o_data    = w_data;
  assign o_busy    = (r_state == CH_HOLD);
  assign o_eff_sel = r_eff_sel;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold;
    w_eff_sel_nxt = r_eff_sel;
    case (r_state)
      CH_ACTIVE: begin
        if (w_sel_change) begin
          if (SETTLE == 0) begin
            w_eff_sel_nxt = i_new_sel;
          end else begin
            w_hold_nxt  = w_data;
            w_cnt_nxt   = RELOAD;
            w_state_nxt = CH_HOLD;
          end
        end
      end
      CH_HOLD: begin
        // A retrigger restarts the settle window but keeps the frozen value.
        if (w_sel_change) begin
          w_cnt_nxt = RELOAD;
        end else if (r_cnt == '0) begin
          w_eff_sel_nxt = i_upd_sel;
          w_state_nxt   = CH_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = CH_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CH_ACTIVE;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_eff_sel <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hold    <= w_hold_nxt;
      r_eff_sel <= w_eff_sel_nxt;
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctl.sv
// IJTAG-controlled override mux: shared shift/update data register plus CHANNELS
// independent channels that switch between functional and IJTAG-supplied data.
module firebird7_in_gate1_tessent_data_mux_ctl
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int SETTLE   = 2
) (
  input  logic                      ijtag_tck,
  input  logic                      ijtag_reset,
  input  logic                      ijtag_sel,
  input  logic                      ijtag_ce,
  input  logic                      ijtag_se,
  input  logic                      ijtag_ue,
  input  logic                      ijtag_si,
  output logic                      ijtag_so,
  input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       switch_busy
);

  localparam int SW = slice_w(WIDTH);
  localparam int L  = CHANNELS * SW;

  logic [L-1:0]        r_shift;
  logic [L-1:0]        r_upd;
  logic [L-1:0]        w_capture;
  logic [CHANNELS-1:0] w_eff_sel;
  logic                w_upd_en;

  assign w_upd_en = ijtag_sel && ijtag_ue;
  assign ijtag_so = r_shift[0];

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_shift <= '0;
      r_upd   <= '0;
    end else begin
      if (ijtag_sel) begin
        if (ijtag_ce) begin
          r_shift <= w_capture;
        end else if (ijtag_se) begin
          r_shift <= {ijtag_si, r_shift[L-1:1]};
        end
      end
      // Update samples the pre-edge shift register even when capture/shift fire too.
      if (w_upd_en) begin
        r_upd <= r_shift;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    // Capture reports the effective select, which lags the update during a hold.
    assign w_capture[c*SW +: SW] = {w_eff_sel[c], functional_data_in[c*WIDTH +: WIDTH]};

    firebird7_in_gate1_tessent_data_mux_chan #(
      .WIDTH  (WIDTH),
      .SETTLE (SETTLE)
    ) u_chan (
      .clk         (ijtag_tck),
      .rst_n       (ijtag_reset),
      .i_upd_en    (w_upd_en),
      .i_new_sel   (r_shift[c*SW + WIDTH]),
      .i_upd_sel   (r_upd[c*SW + WIDTH]),
      .i_upd_data  (r_upd[c*SW +: WIDTH]),
      .i_func_data (functional_data_in[c*WIDTH +: WIDTH]),
      .o_data      (data_out[c*WIDTH +: WIDTH]),
      .o_busy      (switch_busy[c]),
      .o_eff_sel   (w_eff_sel[c])
    );
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctl.sv
// Directed self-checking bench for the IJTAG override mux (WIDTH=3, CHANNELS=4, SETTLE=2).
module tb_firebird7_in_gate1_tessent_data_mux_ctl;

  logic        tck;
  logic        rst_n;
  logic        sel, ce, se, ue, si;
  logic        so;
  logic [11:0] func;
  logic [11:0] dout;
  logic [3:0]  busy;
  logic [15:0] scan_data;

  int n_vec;
  int n_err;

  firebird7_in_gate1_tessent_data_mux_ctl #(
    .WIDTH    (3),
    .CHANNELS (4),
    .SETTLE   (2)
  ) dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst_n),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (func),
    .data_out           (dout),
    .switch_busy        (busy)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  // Shift din in LSB first while collecting what falls out of ijtag_so.
  task automatic scan(input logic [15:0] din, output logic [15:0] dout_v);
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dout_v[i] = so;
      si = din[i];
      tick();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic update();
    sel = 1'b1;
    ue  = 1'b1;
    tick();
    ue  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    func = 12'hA5C;

    // Reset: pure passthrough.
    #1;
    check("rst_data", 32'(dout), 32'hA5C);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_so",   32'(so),   32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_data", 32'(dout), 32'hA5C);

    // Shift ch1 = {1,110} and update: 2-cycle hold of old functional value (3).
    scan(16'h00E0, scan_data);
    check("scan_no_effect", 32'(dout), 32'hA5C);
    update();
    check("ovr_busy_k", 32'(busy), 32'h2);
    check("ovr_hold_k", 32'(dout), 32'hA5C);
    func = 12'h5A3;
    #1;
    check("ovr_hold_track", 32'(dout), 32'h59B);
    tick();
    check("ovr_busy_k1", 32'(busy), 32'h2);
    check("ovr_hold_k1", 32'(dout), 32'h59B);
    tick();
    check("ovr_busy_k2", 32'(busy), 32'h0);
    check("ovr_data_k2", 32'(dout), 32'h5B3);

    // Data-only update: immediate, no busy.
    scan(16'h00B0, scan_data);
    update();
    check("dat_busy", 32'(busy), 32'h0);
    check("dat_data", 32'(dout), 32'h59B);
    tick();
    check("dat_busy_k1", 32'(busy), 32'h0);

    // Capture with ch1 overridden, then read the register out.
    func = 12'h123;
    #1;
    check("cap_data", 32'(dout), 32'h11B);
    sel = 1'b1;
    ce  = 1'b1;
    tick();
    ce  = 1'b0;
    check("cap_so", 32'(so), 32'h1);
    scan(16'h0000, scan_data);
    check("cap_scan", 32'(scan_data), 32'h04C3);

    // Retrigger on ch2: update+capture together, then update the captured value back.
    scan(16'h08B0, scan_data);
    ue = 1'b1;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    check("rt_busy_k",  32'(busy), 32'h4);
    check("rt_data_k",  32'(dout), 32'h11B);
    tick();
    ue = 1'b0;
    check("rt_busy_k1", 32'(busy), 32'h4);
    check("rt_data_k1", 32'(dout), 32'h123);
    func = 12'h1E3;
    #1;
    check("rt_hold_frozen", 32'(dout), 32'h123);
    tick();
    check("rt_busy_k2", 32'(busy), 32'h4);
    check("rt_data_k2", 32'(dout), 32'h123);
    tick();
    check("rt_busy_k3", 32'(busy), 32'h0);
    check("rt_data_k3", 32'(dout), 32'h1E3);

    // Mid-hold asynchronous reset on ch0.
    scan(16'h00CD, scan_data);
    update();
    check("mr_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_busy_rst", 32'(busy), 32'h0);
    check("mr_data_rst", 32'(dout), 32'h1E3);
    check("mr_so_rst",   32'(so),   32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Enables with sel=0 are ignored.
    scan(16'h00E0, scan_data);
    sel = 1'b0;
    ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    check("ds_so",   32'(so),   32'h0);
    check("ds_busy", 32'(busy), 32'h0);
    check("ds_data", 32'(dout), 32'h1E3);
    scan(16'h0000, scan_data);
    check("ds_scan", 32'(scan_data), 32'h00E0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctl.md
# firebird7_in_gate1_tessent_data_mux_ctl

Parametrised IJTAG-controlled override mux for `firebird7_in_gate1`. It provides CHANNELS independent WIDTH-bit channels, each switchable between functional data and IJTAG-supplied data. Select and override data are loaded through an integrated shift/update data register on the IJTAG network. A per-channel settle hold freezes the output across any select change.

## Interface
- `WIDTH`, 3: data bits per channel (≥1).
- `CHANNELS`, 4: number of independent channels (≥1).
- `SETTLE`, 2: hold cycles after a select change (0..15); 0 means immediate switch.
- `ijtag_tck` input 1: sole clock; all state updates on the rising edge.
- `ijtag_reset` input 1: reset, asynchronous, active-low.
- `ijtag_sel` input 1: this data register is selected on the IJTAG network.
- `ijtag_ce` input 1: capture enable.
- `ijtag_se` input 1: shift enable.
- `ijtag_ue` input 1: update enable.
- `ijtag_si` input 1: scan in.
- `ijtag_so` output 1: scan out, equal to `shift_reg[0]`.
- `functional_data_in` input CHANNELS*WIDTH: channel c occupies `[c*WIDTH +: WIDTH]`.
- `data_out` output CHANNELS*WIDTH: muxed data, same packing as `functional_data_in`.
- `switch_busy` output CHANNELS: channel c is in its settle hold.

## Operation
- Register length `L = CHANNELS*(WIDTH+1)`. Each channel c owns slice `[c*(WIDTH+1) +: WIDTH+1]`, laid out as `{sel, data[WIDTH-1:0]}`.
- Shift register, updated only when `ijtag_sel`=1:
  - `ce` loads per channel `{eff_sel_c, functional_data_in_c}`.
  - Otherwise `se` shifts right: `{ijtag_si, shift_reg[L-1:1]}`.
  - Capture has priority over shift.
- Update register: when `ijtag_sel && ijtag_ue`, it loads `shift_reg` on the same rising edge. `ue` is independent of `ce`/`se`. If all three are asserted together, update takes the pre-edge `shift_reg`.
- Each channel runs a two-state FSM, `CH_ACTIVE` and `CH_HOLD`:
  - **`CH_ACTIVE`**: `data_out_c = eff_sel_c ? upd_data_c : functional_data_in_c`. This path is combinational, so an update that changes only the data bits is visible the cycle after the update edge, with no hold.
  - **Entering hold**: an update edge that changes the channel's sel bit with `SETTLE`>0 does three things: `hold_reg_c` ← current `data_out_c`; `cnt_c` ← SETTLE−1; state → `CH_HOLD`.
  - **Switching with `SETTLE`=0**: `eff_sel_c` ← new sel on the same edge.
  - **`CH_HOLD`**: `data_out_c = hold_reg_c` and `switch_busy_c`=1.
    - While `cnt_c` is nonzero, it decrements each cycle.
    - When `cnt_c`=0: `eff_sel_c` ← `upd_sel_c` and state → `CH_ACTIVE`.
    - A further sel change during `CH_HOLD` reloads `cnt_c` to SETTLE−1 and keeps `hold_reg_c` unchanged.
    - On exit, `eff_sel_c` takes the latest `upd_sel_c`. If sel has toggled back to the original value, it still exits cleanly with no glitch.
- Capture reports `eff_sel_c`, not `upd_sel_c`. During a hold this is still the old select.
- Channels are fully independent; any combination may be busy.

## Timing
- Reset values:
  - `shift_reg`, `upd_reg`, `eff_sel`, `hold_reg` and `cnt` are all 0.
  - All channels are in `CH_ACTIVE`.
  - `ijtag_so`=0 and `switch_busy`=0.
  - `data_out` = `functional_data_in`, passed through combinationally.
- Reset asserted mid-hold or mid-shift: abandons the operation immediately, and outputs return to the reset values asynchronously.
- Functional-to-output path: 0 cycles, combinational, in `CH_ACTIVE`.
- Select change, with the update at edge k:
  - `switch_busy` is high from edge k until edge k+SETTLE.
  - The new source drives `data_out` after edge k+SETTLE.
- `ijtag_so` changes only on rising edges. It is the registered `shift_reg[0]`.
- Enables with `ijtag_sel`=0 are ignored entirely.

## Structure
- Package `firebird7_in_gate1_tessent_data_mux_pkg` holds:
  - enum `ch_state_t` with values {`CH_ACTIVE`, `CH_HOLD`};
  - localparam function `slice_w(WIDTH)` = WIDTH+1;
  - counter width constant `CNT_W` = 4.
- Sub-module `firebird7_in_gate1_tessent_data_mux_chan` implements one channel's FSM, counter, hold register and output mux. The top level instantiates it CHANNELS times with a generate loop and owns the shift and update registers.

## Test plan
All scenarios use WIDTH=3, CHANNELS=4, SETTLE=2.
- **Reset**: `ijtag_reset`=0 with `functional_data_in`=12'hA5C → `data_out`=12'hA5C, `switch_busy`=0, `ijtag_so`=0.
- **Shift and update to override**: shift 16 bits placing ch1 = {1,3'b110}, then update → ch1 `switch_busy` high for exactly 2 cycles holding the old functional value, then ch1 `data_out`=3'b110; channels 0, 2 and 3 keep tracking the functional input.
- **Data-only update**: with ch1 already overridden, update ch1 = {1,3'b011} → `data_out` ch1 = 3'b011 the next cycle, `switch_busy` never asserts.
- **Capture**: `functional_data_in`=12'h123 and ch1 overridden, then capture and shift out 16 bits → ch1 slice reads sel=1; the other channels read sel=0 plus their functional data.
- **Retrigger during hold**: toggle ch2 sel, then toggle it back one cycle later → busy lasts 3 cycles total, `hold_reg` is unchanged throughout, and the channel finishes on the functional source.
- **Mid-hold reset and deselect**: assert `ijtag_reset` during a ch0 hold → immediate functional passthrough with busy=0. Separately, pulse `ce`/`se`/`ue` with `ijtag_sel`=0 → no state change.
